// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word/line widths, arbiter state and request payload.
package lc3b_types;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned LINE_W = 128;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2,
        ARB_RECOVER = 2'd3
    } lc3b_arb_state;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } lc3b_arb_side;

    // Request captured at grant time; the L2 port is driven only from this.
    typedef struct packed {
        logic          write;
        lc3b_word      addr;
        lc3b_cacheline wdata;
    } lc3b_l2_req;

endpackage

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-cache and D-cache.
module l2_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst_n,

    input  logic          i_mem_read,
    input  lc3b_word      i_mem_address,
    output lc3b_cacheline i_mem_rdata,
    output logic          i_mem_resp,

    input  logic          d_mem_read,
    input  logic          d_mem_write,
    input  lc3b_word      d_mem_address,
    input  lc3b_cacheline d_mem_wdata,
    output lc3b_cacheline d_mem_rdata,
    output logic          d_mem_resp,

    output logic          l2_mem_read,
    output logic          l2_mem_write,
    output lc3b_word      l2_mem_address,
    output lc3b_cacheline l2_mem_wdata,
    input  lc3b_cacheline l2_mem_rdata,
    input  logic          l2_mem_resp
);

    lc3b_arb_state state_q, state_d;
    lc3b_arb_side  last_grant_q, last_grant_d;
    lc3b_l2_req    hold_q, hold_d;

    logic i_valid;
    logic d_valid;

    // A D request with both strobes high is malformed and never granted.
    assign i_valid = i_mem_read;
    assign d_valid = d_mem_read ^ d_mem_write;

    // State, grant history and holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_D;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
        end
    end

    // Next-state, grant selection and L2/L1 port drive.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        hold_d         = hold_q;
        l2_mem_read    = 1'b0;
        l2_mem_write   = 1'b0;
        l2_mem_address = '0;
        l2_mem_wdata   = '0;
        i_mem_resp     = 1'b0;
        i_mem_rdata    = '0;
        d_mem_resp     = 1'b0;
        d_mem_rdata    = '0;

        case (state_q)
            ARB_IDLE: begin
                // On a tie, the side that did not win last time goes first.
                if (i_valid && (!d_valid || last_grant_q == GRANT_D)) begin
                    state_d      = ARB_SERVE_I;
                    last_grant_d = GRANT_I;
                    hold_d.write = 1'b0;
                    hold_d.addr  = i_mem_address;
                    hold_d.wdata = '0;
                end else if (d_valid) begin
                    state_d      = ARB_SERVE_D;
                    last_grant_d = GRANT_D;
                    hold_d.write = d_mem_write;
                    hold_d.addr  = d_mem_address;
                    hold_d.wdata = d_mem_write ? d_mem_wdata : '0;
                end
            end

            ARB_SERVE_I: begin
                l2_mem_read    = 1'b1;
                l2_mem_address = hold_q.addr;
                if (l2_mem_resp) begin
                    i_mem_resp  = 1'b1;
                    i_mem_rdata = l2_mem_rdata;
                    state_d     = ARB_RECOVER;
                end
            end

            ARB_SERVE_D: begin
                l2_mem_read    = ~hold_q.write;
                l2_mem_write   = hold_q.write;
                l2_mem_address = hold_q.addr;
                l2_mem_wdata   = hold_q.wdata;
                if (l2_mem_resp) begin
                    d_mem_resp  = 1'b1;
                    d_mem_rdata = l2_mem_rdata;
                    state_d     = ARB_RECOVER;
                end
            end

            // One dead cycle lets the served L1 drop its request before re-arbitration.
            ARB_RECOVER: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_l2_arbiter;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_mem_read;
    lc3b_word      i_mem_address;
    lc3b_cacheline i_mem_rdata;
    logic          i_mem_resp;
    logic          d_mem_read;
    logic          d_mem_write;
    lc3b_word      d_mem_address;
    lc3b_cacheline d_mem_wdata;
    lc3b_cacheline d_mem_rdata;
    logic          d_mem_resp;
    logic          l2_mem_read;
    logic          l2_mem_write;
    lc3b_word      l2_mem_address;
    lc3b_cacheline l2_mem_wdata;
    lc3b_cacheline l2_mem_rdata;
    logic          l2_mem_resp;

    logic [403:0] out_all;
    logic [145:0] l2_port;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit m_last_d;

    l2_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
        .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
        .l2_mem_address(l2_mem_address), .l2_mem_wdata(l2_mem_wdata),
        .l2_mem_rdata(l2_mem_rdata), .l2_mem_resp(l2_mem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign out_all = {l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata,
                      i_mem_resp, d_mem_resp, i_mem_rdata, d_mem_rdata};
    assign l2_port = {l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata};

    function automatic lc3b_cacheline rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Round-robin rule: a lone valid requester wins; a tie goes to the side not granted last.
    function automatic bit model_grant_d(bit iv, bit dv, bit last_d);
        if (iv && dv) return !last_d;
        return dv;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_mem_read = 1'b0; i_mem_address = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0;
        d_mem_address = '0; d_mem_wdata = '0;
        l2_mem_resp = 1'b0; l2_mem_rdata = '0;
    endtask

    task automatic drive_req(input bit ip, input lc3b_word ia, input bit dp, input bit dw,
                             input lc3b_word da, input lc3b_cacheline dwd);
        i_mem_read = ip; i_mem_address = ia;
        d_mem_read = dp && !dw; d_mem_write = dp && dw;
        d_mem_address = da; d_mem_wdata = dwd;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        m_last_d = 1'b1;
    endtask

    task automatic test_reset();
        i_mem_read = 1'b1; i_mem_address = 16'hBEEF;
        d_mem_read = 1'b1; d_mem_write = 1'b0; d_mem_address = 16'hCAFE;
        d_mem_wdata = rand_line(); l2_mem_resp = 1'b1; l2_mem_rdata = rand_line();
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_all !== '0) begin n_err++; $display("FAIL reset_immediate got %h want 0", out_all); end
        tick(); tick();
        @(negedge clk);
        n_vec++; if (out_all !== '0) begin n_err++; $display("FAIL reset_held got %h want 0", out_all); end
        tick();
        idle_inputs();
        l2_mem_resp = 1'b1; l2_mem_rdata = rand_line();
        rst_n = 1'b1; m_last_d = 1'b1;
        @(negedge clk);
        n_vec++; if (out_all !== '0) begin n_err++; $display("FAIL idle_stray_resp got %h want 0", out_all); end
        tick();
        l2_mem_resp = 1'b0;
    endtask

    task automatic test_i_read_alone();
        lc3b_cacheline a5 = {16{8'hA5}};
        apply_reset();
        drive_req(1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({l2_mem_read, l2_mem_write, l2_mem_address, i_mem_resp, d_mem_resp} !== {2'b10, 16'h1230, 2'b00}) begin
                n_err++;
                $display("FAIL i_alone_strobe c%0d got rd=%b wr=%b addr=%h resp=%b%b want rd=1 wr=0 addr=1230 resp=00",
                         c, l2_mem_read, l2_mem_write, l2_mem_address, i_mem_resp, d_mem_resp);
            end
            tick();
        end
        l2_mem_resp = 1'b1; l2_mem_rdata = a5;
        @(negedge clk);
        n_vec++; if ({i_mem_resp, d_mem_resp} !== 2'b10) begin n_err++; $display("FAIL i_alone_resp got %b%b want 10", i_mem_resp, d_mem_resp); end
        n_vec++; if (i_mem_rdata !== a5) begin n_err++; $display("FAIL i_alone_rdata got %h want %h", i_mem_rdata, a5); end
        tick();
        l2_mem_resp = 1'b0; i_mem_read = 1'b0;
        @(negedge clk);
        n_vec++; if (out_all !== '0) begin n_err++; $display("FAIL i_alone_recover got %h want 0", out_all); end
        tick();
        @(negedge clk);
        n_vec++; if (out_all !== '0) begin n_err++; $display("FAIL i_alone_idle got %h want 0", out_all); end
        tick();
    endtask

    task automatic test_tie_after_reset();
        lc3b_cacheline w1 = {8{16'h1111}};
        lc3b_cacheline rd;
        bit gd;
        apply_reset();
        drive_req(1'b1, 16'h0040, 1'b1, 1'b1, 16'h8000, w1);
        gd = model_grant_d(1'b1, 1'b1, m_last_d); m_last_d = gd;
        tick();
        @(negedge clk);
        n_vec++;
        if (l2_mem_address !== (gd ? 16'h8000 : 16'h0040) || l2_mem_read !== !gd) begin
            n_err++; $display("FAIL tie_first got addr=%h rd=%b want addr=%h rd=%b", l2_mem_address, l2_mem_read, gd ? 16'h8000 : 16'h0040, !gd);
        end
        tick();
        l2_mem_resp = 1'b1; l2_mem_rdata = rand_line();
        @(negedge clk);
        n_vec++; if ({i_mem_resp, d_mem_resp} !== {!gd, gd}) begin n_err++; $display("FAIL tie_first_resp got %b%b want %b%b", i_mem_resp, d_mem_resp, !gd, gd); end
        tick();
        l2_mem_resp = 1'b0; i_mem_read = 1'b0;
        tick(); tick();
        gd = model_grant_d(1'b0, 1'b1, m_last_d); m_last_d = gd;
        @(negedge clk);
        n_vec++;
        if (l2_port !== {2'b01, 16'h8000, w1}) begin
            n_err++; $display("FAIL tie_second_port got %h want %h", l2_port, {2'b01, 16'h8000, w1});
        end
        tick(); tick();
        rd = rand_line(); l2_mem_resp = 1'b1; l2_mem_rdata = rd;
        @(negedge clk);
        n_vec++; if ({i_mem_resp, d_mem_resp, d_mem_rdata} !== {2'b01, rd}) begin n_err++; $display("FAIL tie_second_resp got %b%b %h want 01 %h", i_mem_resp, d_mem_resp, d_mem_rdata, rd); end
        tick();
        l2_mem_resp = 1'b0; d_mem_write = 1'b0;
        @(negedge clk);
        n_vec++; if (d_mem_resp !== 1'b0) begin n_err++; $display("FAIL tie_single_pulse got %b want 0", d_mem_resp); end
        tick();
    endtask

    task automatic test_d_both_strobes();
        int bad = 0;
        lc3b_word ia = lc3b_word'($urandom);
        apply_reset();
        i_mem_read = 1'b1; i_mem_address = ia;
        d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 16'h7777; d_mem_wdata = rand_line();
        m_last_d = model_grant_d(1'b1, 1'b0, m_last_d);
        tick();
        @(negedge clk);
        n_vec++; if ({l2_mem_read, l2_mem_write, l2_mem_address} !== {2'b10, ia}) begin n_err++; $display("FAIL dboth_i_port got %b%b %h want 10 %h", l2_mem_read, l2_mem_write, l2_mem_address, ia); end
        tick();
        l2_mem_resp = 1'b1; l2_mem_rdata = rand_line();
        @(negedge clk);
        n_vec++; if ({i_mem_resp, d_mem_resp} !== 2'b10) begin n_err++; $display("FAIL dboth_i_resp got %b%b want 10", i_mem_resp, d_mem_resp); end
        tick();
        l2_mem_resp = 1'b0; i_mem_read = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (l2_mem_read || l2_mem_write || d_mem_resp || i_mem_resp) bad++;
            tick();
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL dboth_ignored got %0d active cycles want 0", bad); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_serve();
        int bad = 0;
        lc3b_word ia = lc3b_word'($urandom);
        bit gd;
        apply_reset();
        drive_req(1'b0, '0, 1'b1, 1'b0, 16'h4000, '0);
        m_last_d = model_grant_d(1'b0, 1'b1, m_last_d);
        tick();
        @(negedge clk);
        n_vec++; if ({l2_mem_read, l2_mem_address} !== {1'b1, 16'h4000}) begin n_err++; $display("FAIL rst_mid_pre got %b %h want 1 4000", l2_mem_read, l2_mem_address); end
        tick();
        #1 rst_n = 1'b0;
        idle_inputs();
        #1;
        n_vec++; if (out_all !== '0) begin n_err++; $display("FAIL rst_mid_immediate got %h want 0", out_all); end
        tick();
        rst_n = 1'b1; m_last_d = 1'b1;
        for (int c = 0; c < 3; c++) begin
            l2_mem_resp = 1'b1; l2_mem_rdata = rand_line();
            @(negedge clk);
            if (out_all !== '0) bad++;
            tick();
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rst_mid_no_resp got %0d active cycles want 0", bad); end
        l2_mem_resp = 1'b0;
        drive_req(1'b1, ia, 1'b1, 1'b0, 16'h5000, '0);
        gd = model_grant_d(1'b1, 1'b1, m_last_d); m_last_d = gd;
        tick();
        @(negedge clk);
        n_vec++; if (l2_mem_address !== (gd ? 16'h5000 : ia)) begin n_err++; $display("FAIL rst_mid_tie got %h want %h", l2_mem_address, gd ? 16'h5000 : ia); end
        idle_inputs();
    endtask

    task automatic test_addr_change();
        apply_reset();
        drive_req(1'b0, '0, 1'b1, 1'b0, 16'h8000, '0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin d_mem_address = 16'h9000; i_mem_read = 1'b1; i_mem_address = 16'h2222; end
            if (k == 4) begin l2_mem_resp = 1'b1; l2_mem_rdata = rand_line(); end
            @(negedge clk);
            n_vec++; if ({l2_mem_read, l2_mem_address} !== {1'b1, 16'h8000}) begin n_err++; $display("FAIL addr_hold k%0d got %b %h want 1 8000", k, l2_mem_read, l2_mem_address); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_traffic(input int n_txn, input bit force_both);
        bit ip = 0, dp = 0, dw = 0, gd, hit;
        lc3b_word ia = '0, da = '0;
        lc3b_cacheline dwd = '0, rd;
        logic [145:0] exp_l2;
        logic [31:0] seq = '0, exp_seq = '0;
        int lat;
        int last_resp = -1;
        apply_reset();
        for (int t = 0; t < n_txn; t++) begin
            if (!ip) begin ip = force_both || ($urandom_range(0, 1) == 1); ia = lc3b_word'($urandom); end
            if (!dp) begin
                dp = force_both || ($urandom_range(0, 1) == 1);
                da = lc3b_word'($urandom); dw = ($urandom_range(0, 1) == 1); dwd = rand_line();
            end
            if (!ip && !dp) ip = 1'b1;
            drive_req(ip, ia, dp, dw, da, dwd);
            gd = model_grant_d(ip, dp, m_last_d); m_last_d = gd;
            if (gd) exp_l2 = {!dw, dw, da, dw ? dwd : 128'h0};
            else    exp_l2 = {2'b10, ia, 128'h0};
            exp_seq[t] = t[0];
            tick();
            lat = $urandom_range(0, 4);
            for (int k = 0; k <= lat; k++) begin
                hit = (k == lat);
                rd = rand_line();
                l2_mem_resp = hit; l2_mem_rdata = rd;
                // The in-flight requester scribbles on its address/data; L2 must not see it.
                if (k > 0 && gd)  begin d_mem_address = lc3b_word'($urandom); d_mem_wdata = rand_line(); end
                if (k > 0 && !gd) i_mem_address = lc3b_word'($urandom);
                @(negedge clk);
                n_vec++; if (l2_port !== exp_l2) begin n_err++; $display("FAIL traffic_port t%0d k%0d got %h want %h", t, k, l2_port, exp_l2); end
                n_vec++; if ({i_mem_resp, d_mem_resp} !== {hit && !gd, hit && gd}) begin n_err++; $display("FAIL traffic_resp t%0d k%0d got %b%b want %b%b", t, k, i_mem_resp, d_mem_resp, hit && !gd, hit && gd); end
                n_vec++; if (i_mem_rdata !== ((hit && !gd) ? rd : 128'h0)) begin n_err++; $display("FAIL traffic_irdata t%0d k%0d got %h", t, k, i_mem_rdata); end
                n_vec++; if (d_mem_rdata !== ((hit && gd) ? rd : 128'h0)) begin n_err++; $display("FAIL traffic_drdata t%0d k%0d got %h", t, k, d_mem_rdata); end
                if (hit) begin
                    if (last_resp >= 0) begin
                        n_vec++; if (cyc - last_resp < 3) begin n_err++; $display("FAIL traffic_spacing t%0d got %0d cycles want >=3", t, cyc - last_resp); end
                    end
                    last_resp = cyc;
                    seq[t] = d_mem_resp;
                end
                tick();
            end
            if (gd) begin
                dp = force_both || ($urandom_range(0, 1) == 1);
                if (dp) begin da = lc3b_word'($urandom); dw = ($urandom_range(0, 1) == 1); dwd = rand_line(); end
            end else begin
                ip = force_both || ($urandom_range(0, 1) == 1);
                if (ip) ia = lc3b_word'($urandom);
            end
            drive_req(ip, ia, dp, dw, da, dwd);
            l2_mem_resp = ($urandom_range(0, 1) == 1); l2_mem_rdata = rand_line();
            @(negedge clk);
            n_vec++; if (out_all !== '0) begin n_err++; $display("FAIL traffic_recover t%0d got %h want 0", t, out_all); end
            tick();
            l2_mem_resp = 1'b0;
        end
        if (force_both) begin
            n_vec++; if (seq !== exp_seq) begin n_err++; $display("FAIL alternate_order got %b want %b (1=D)", seq, exp_seq); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_i_read_alone();
        test_tie_after_reset();
        test_d_both_strobes();
        test_reset_mid_serve();
        test_addr_change();
        test_traffic(6, 1'b1);
        test_traffic(40, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameters: none; widths come from shared types (lc3b_word = 16 bits, lc3b_cacheline = 128 bits).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_mem_read  input  1  I-cache line read request, held until i_mem_resp.
REQ-005 i_mem_address  input  16  I-cache line address.
REQ-006 i_mem_rdata  output  128  line returned to I-cache, valid when i_mem_resp=1.
REQ-007 i_mem_resp  output  1  one-cycle completion pulse to I-cache.
REQ-008 d_mem_read, d_mem_write  input  1 each  D-cache line read / writeback request, held until d_mem_resp.
REQ-009 d_mem_address  input  16  D-cache line address.
REQ-010 d_mem_wdata  input  128  D-cache writeback line.
REQ-011 d_mem_rdata  output  128  line returned to D-cache, valid when d_mem_resp=1.
REQ-012 d_mem_resp  output  1  one-cycle completion pulse to D-cache.
REQ-013 l2_mem_read, l2_mem_write  output  1 each  request strobes to L2 cache.
REQ-014 l2_mem_address  output  16  L2 request address.
REQ-015 l2_mem_wdata  output  128  L2 write line.
REQ-016 l2_mem_rdata  input  128  L2 read line.
REQ-017 l2_mem_resp  input  1  L2 completion pulse.

Function
REQ-018 FSM states: IDLE, SERVE_I, SERVE_D, RECOVER.
REQ-019 Valid I request: i_mem_read=1; valid D request: d_mem_read XOR d_mem_write; D with both strobes high is ignored.
REQ-020 IDLE, one valid request: latch address (and wdata, op for D) into holding registers; go to SERVE_I/SERVE_D next edge.
REQ-021 IDLE, both valid: round-robin on last_grant register; grant side not equal to last_grant; update last_grant on grant.
REQ-022 SERVE_x: drive l2 strobes/address/wdata solely from holding registers; exactly one of l2_mem_read/l2_mem_write high.
REQ-023 SERVE_x with l2_mem_resp=1: same cycle pulse x_mem_resp=1, x_mem_rdata=l2_mem_rdata (combinational pass-through); next state RECOVER.
REQ-024 RECOVER: all l2 strobes and resps low, no grant taken; next state IDLE (gives L1 one cycle to drop request).
REQ-025 Latency: request seen in IDLE at cycle 0 -> l2 strobe at cycle 1 -> resp same cycle as l2_mem_resp; minimum 3 cycles between grants.
REQ-026 Requester inputs changing during SERVE_x have no effect on the L2 transaction in flight.
REQ-027 i_mem_rdata/d_mem_rdata SHALL be 0 when the corresponding resp is 0.
REQ-028 l2_mem_resp outside SERVE_x is ignored; no resp pulse generated.
REQ-029 Never more than one of i_mem_resp, d_mem_resp high in any cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, last_grant=D, holding registers=0, all outputs=0.
REQ-031 Reset during SERVE_x SHALL abandon the transaction; no resp pulse is issued for it after reset release.
REQ-032 First tie after reset SHALL be granted to I.

Structure
REQ-033 lc3b_word, lc3b_cacheline and new enum lc3b_arb_state SHALL reside in package lc3b_types.
REQ-034 Single flat module; no sub-module; holding registers and last_grant in one always_ff with asynchronous reset.

Verification
REQ-035 Reset, then I read 0x1230 alone, L2 resp after 4 cycles with line 0xA5..A5 -> l2_mem_read=1/address 0x1230 from cycle 1, i_mem_resp one cycle with rdata 0xA5..A5, RECOVER, IDLE.
REQ-036 I read 0x0040 and D write 0x8000 (wdata 0x1111..11) same cycle after reset -> I served first; then D: l2_mem_write=1, address 0x8000, wdata 0x1111..11; d_mem_resp once.
REQ-037 Both requesting continuously for 6 transactions -> grants alternate I,D,I,D,I,D; no back-to-back resps closer than 3 cycles.
REQ-038 D asserts read and write together -> no L2 strobe, no resp; I request concurrently served normally.
REQ-039 rst_n low for 1 cycle during SERVE_D while L2 pending -> outputs zero immediately; later l2_mem_resp produces no d_mem_resp; next tie grants I.
REQ-040 d_mem_address changes 0x8000->0x9000 mid SERVE_D -> l2_mem_address stays 0x8000 until resp.
